// File: rtl/rx_halfband_decim_if.sv
// Sample stream bundle for the receive halfband decimator.
// CIC-side inputs, filtered outputs and the overrun flag.
interface rx_halfband_decim_if;
  logic               strobe_in;
  logic signed [23:0] i_in;
  logic signed [23:0] q_in;
  logic               strobe_out;
  logic signed [23:0] i_out;
  logic signed [23:0] q_out;
  logic               overrun;

  modport master (
    output strobe_in, i_in, q_in,
    input  strobe_out, i_out, q_out, overrun
  );

  modport slave (
    input  strobe_in, i_in, q_in,
    output strobe_out, i_out, q_out, overrun
  );
endinterface

// File: rtl/rx_halfband_decim.sv
// Decimate-by-2 15-tap halfband FIR on 24-bit I/Q.
// One shared pre-add/multiply per channel, sequenced by a small FSM.
module rx_halfband_decim #(
  parameter logic signed [17:0] C0 = -18'sd512,
  parameter logic signed [17:0] C1 = 18'sd3072,
  parameter logic signed [17:0] C2 = -18'sd10240,
  parameter logic signed [17:0] C3 = 18'sd40448,
  parameter logic signed [17:0] CC = 18'sd65536
) (
  input logic clock,
  input logic reset,
  input logic enable,
  rx_halfband_decim_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, P0, P1, P2, P3, CTR, OUT
  } state_t;

  state_t state, nxt;

  logic               phase;
  logic               accept;
  logic               drop;
  logic               first;
  logic               mac_en;
  logic               fin;
  logic               solo;
  logic [3:0]         ia;
  logic [3:0]         ib;
  logic signed [17:0] coef;

  logic signed [23:0] xi [15];
  logic signed [23:0] xq [15];
  logic signed [24:0] pre_i, pre_q;
  logic signed [42:0] prod_i, prod_q;
  logic signed [45:0] acc_i, acc_q;
  logic signed [23:0] i_r, q_r;
  logic               stb_r, ovr_r;

  function automatic logic signed [23:0] sat(
    input logic signed [45:0] a
  );
    logic signed [45:0] r;
    r = (a + 46'sd65536) >>> 17;
    if (r > 46'sd8388607)
      return 24'sh7fffff;
    if (r < -46'sd8388608)
      return 24'sh800000;
    return r[23:0];
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      state <= IDLE;
    else if (!enable)
      state <= IDLE;
    else
      state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: if (bus.strobe_in && phase) nxt = P0;
      P0:   nxt = P1;
      P1:   nxt = P2;
      P2:   nxt = P3;
      P3:   nxt = CTR;
      CTR:  nxt = OUT;
      OUT:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // tap pair select; the centre tap has no mirror partner
  always_comb begin
    accept = bus.strobe_in && (state == IDLE);
    drop   = bus.strobe_in && (state != IDLE);
    mac_en = 1'b1;
    first  = 1'b0;
    fin    = 1'b0;
    solo   = 1'b0;
    ia     = 4'd0;
    ib     = 4'd14;
    coef   = C0;
    unique case (state)
      P0: first = 1'b1;
      P1: begin
        ia   = 4'd2;
        ib   = 4'd12;
        coef = C1;
      end
      P2: begin
        ia   = 4'd4;
        ib   = 4'd10;
        coef = C2;
      end
      P3: begin
        ia   = 4'd6;
        ib   = 4'd8;
        coef = C3;
      end
      CTR: begin
        ia   = 4'd7;
        solo = 1'b1;
        coef = CC;
      end
      OUT: begin
        mac_en = 1'b0;
        fin    = 1'b1;
      end
      default: mac_en = 1'b0;
    endcase
  end

  always_comb begin
    pre_i = {xi[ia][23], xi[ia]};
    pre_q = {xq[ia][23], xq[ia]};
    if (!solo) begin
      pre_i = pre_i + {xi[ib][23], xi[ib]};
      pre_q = pre_q + {xq[ib][23], xq[ib]};
    end
    prod_i = 43'(pre_i) * 43'(coef);
    prod_q = 43'(pre_q) * 43'(coef);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 15; k++) begin
        xi[k] <= '0;
        xq[k] <= '0;
      end
      phase <= 1'b0;
    end else if (!enable) begin
      for (int k = 0; k < 15; k++) begin
        xi[k] <= '0;
        xq[k] <= '0;
      end
      phase <= 1'b0;
    end else if (accept) begin
      xi[0] <= bus.i_in;
      xq[0] <= bus.q_in;
      for (int k = 1; k < 15; k++) begin
        xi[k] <= xi[k-1];
        xq[k] <= xq[k-1];
      end
      phase <= ~phase;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc_i <= '0;
      acc_q <= '0;
      i_r   <= '0;
      q_r   <= '0;
      stb_r <= 1'b0;
      ovr_r <= 1'b0;
    end else if (!enable) begin
      acc_i <= '0;
      acc_q <= '0;
      i_r   <= '0;
      q_r   <= '0;
      stb_r <= 1'b0;
      ovr_r <= 1'b0;
    end else begin
      stb_r <= fin;
      ovr_r <= drop;
      if (mac_en) begin
        acc_i <= first ? 46'(prod_i)
                       : acc_i + 46'(prod_i);
        acc_q <= first ? 46'(prod_q)
                       : acc_q + 46'(prod_q);
      end
      if (fin) begin
        i_r <= sat(acc_i);
        q_r <= sat(acc_q);
      end
    end
  end

  assign bus.strobe_out = stb_r;
  assign bus.i_out      = i_r;
  assign bus.q_out      = q_r;
  assign bus.overrun    = ovr_r;

endmodule

// File: tb/tb_rx_halfband_decim.sv
// Directed bench for rx_halfband_decim with a direct-form
// reference model feeding an expected-output queue.
module tb_rx_halfband_decim;

  logic clock;
  logic reset;
  logic enable;

  rx_halfband_decim_if bus ();

  rx_halfband_decim dut (
    .clock  (clock),
    .reset  (reset),
    .enable (enable),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic signed [23:0] i;
    logic signed [23:0] q;
    int                 cyc;
  } exp_t;

  exp_t   sb [$];
  longint hi [15];
  longint hq [15];
  bit     ph;
  int     cyc;
  int     ovr_cyc;
  int     checks;
  int     errors;

  longint cf [15] = '{
    -512, 0, 3072, 0, -10240, 0, 40448, 65536,
    40448, 0, -10240, 0, 3072, 0, -512
  };

  task automatic chk(
    input string tag,
    input logic signed [63:0] obs,
    input logic signed [63:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d, expected %0d",
             tag, obs, exp);
    end
  endtask

  function automatic logic signed [23:0] model(
    input bit qc
  );
    longint s;
    longint r;
    s = 0;
    for (int k = 0; k < 15; k++)
      s += cf[k] * (qc ? hq[k] : hi[k]);
    r = (s + 65536) >>> 17;
    if (r > 8388607)  r = 8388607;
    if (r < -8388608) r = -8388608;
    return r[23:0];
  endfunction

  task automatic clr_model();
    for (int k = 0; k < 15; k++) begin
      hi[k] = 0;
      hq[k] = 0;
    end
    ph = 1'b0;
    sb.delete();
  endtask

  task automatic tick();
    bit   exp_s;
    exp_t e;
    @(posedge clock);
    #1;
    cyc++;
    chk("overrun", bus.overrun, cyc == ovr_cyc);
    exp_s = sb.size() != 0 && sb[0].cyc == cyc;
    chk("strobe_out", bus.strobe_out, exp_s);
    if (bus.strobe_out && sb.size() != 0) begin
      e = sb.pop_front();
      chk("i_out", bus.i_out, e.i);
      chk("q_out", bus.q_out, e.q);
    end else if (sb.size() != 0 && cyc >= sb[0].cyc) begin
      void'(sb.pop_front());
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  // kind: 0 accepted, 1 dropped while busy, 2 ignored (enable low)
  task automatic send(input int i, input int q, input int kind);
    bus.strobe_in = 1'b1;
    bus.i_in      = i[23:0];
    bus.q_in      = q[23:0];
    if (kind == 1) ovr_cyc = cyc + 1;
    tick();
    bus.strobe_in = 1'b0;
    if (kind == 0) begin
      for (int k = 14; k > 0; k--) begin
        hi[k] = hi[k-1];
        hq[k] = hq[k-1];
      end
      hi[0] = i;
      hq[0] = q;
      ph = !ph;
      if (!ph)
        sb.push_back('{model(0), model(1), cyc + 6});
    end
  endtask

  task automatic do_reset();
    clr_model();
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    idle(1);
  endtask

  initial begin
    cyc     = 0;
    ovr_cyc = -1;
    checks  = 0;
    errors  = 0;
    reset   = 1'b1;
    enable  = 1'b1;
    bus.strobe_in = 1'b0;
    bus.i_in      = '0;
    bus.q_in      = '0;
    clr_model();
    #2;
    chk("rst_i_out", bus.i_out, 0);
    chk("rst_q_out", bus.q_out, 0);
    chk("rst_strobe", bus.strobe_out, 0);
    chk("rst_overrun", bus.overrun, 0);
    idle(2);
    reset = 1'b0;
    idle(2);

    // centre-tap impulse
    for (int n = 0; n < 20; n++) begin
      send(n == 0 ? 131072 : 0, 0, 0);
      idle(9);
    end

    // pair-tap impulse on the second sample
    do_reset();
    for (int n = 0; n < 20; n++) begin
      send(n == 1 ? 131072 : 0, n == 1 ? 131072 : 0, 0);
      idle(9);
    end

    // unity DC gain
    do_reset();
    for (int n = 0; n < 20; n++) begin
      send(1000, -1000, 0);
      idle(9);
    end
    chk("dc_i", bus.i_out, 1000);
    chk("dc_q", bus.q_out, -1000);

    // full scale, alternating Q
    do_reset();
    for (int n = 0; n < 24; n++) begin
      send(8388607, n % 2 ? -8388607 : 8388607, 0);
      idle(9);
    end
    chk("sat_i", bus.i_out, 8388607);

    // latency and overrun
    do_reset();
    send(2000, -3000, 0);
    idle(9);
    send(5000, 7000, 0);
    idle(2);
    send(1234567, -1234567, 1);
    idle(7);
    for (int n = 0; n < 4; n++) begin
      send(300 * n, -100 * n, 0);
      idle(9);
    end

    // reset mid-computation
    do_reset();
    send(7000, 7000, 0);
    idle(9);
    send(7000, 7000, 0);
    idle(9);
    send(2000, -2000, 0);
    idle(9);
    send(2000, -2000, 0);
    idle(2);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_i", bus.i_out, 0);
    chk("async_rst_q", bus.q_out, 0);
    chk("async_rst_stb", bus.strobe_out, 0);
    clr_model();
    idle(2);
    reset = 1'b0;
    idle(8);
    send(5000, 5000, 0);
    idle(9);
    send(5000, 5000, 0);
    idle(9);
    chk("post_rst_i", bus.i_out, -20);

    // enable gating
    enable = 1'b0;
    clr_model();
    for (int n = 0; n < 5; n++) begin
      send(4000, 4000, 2);
      idle(9);
    end
    chk("en_low_i", bus.i_out, 0);
    chk("en_low_q", bus.q_out, 0);
    enable = 1'b1;
    idle(1);
    for (int n = 0; n < 4; n++) begin
      send(3000, -7000, 0);
      idle(9);
    end

    idle(20);
    chk("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
